// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out serializer with valid/ready word intake
//
// Purpose:
//   Takes a WIDTH-bit word on a valid/ready handshake and emits it one bit per
//   clock on serial_out. The shift direction is chosen per word and matches the
//   SIPO encoding: 0 = right/LSB first, 1 = left/MSB first. Words stream back
//   to back with no idle cycle when the next word is offered on the last bit.
//
// Optional feature:
//   SERIALIZER_PARITY_EN - when defined, each frame carries one extra cycle
//   after the data bits with the even parity (XOR) of the word. frame_done and
//   load_ready then move to that parity cycle.
//
// Ports:
//   clk           rising-edge clock
//   reset_n       asynchronous active-low reset
//   load_data     word to serialize
//   load_valid    load_data is valid
//   load_ready    serializer accepts a word this cycle (decoded, not registered)
//   shift_dir     0 = LSB first, 1 = MSB first; sampled when a word is accepted
//   serial_out    current serial bit
//   serial_valid  serial_out carries a frame bit this cycle
//   busy          a frame is in progress
//   frame_done    one-cycle pulse on the final bit of a frame

module piso_serializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_dir,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             busy,
    output logic             frame_done
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
`ifdef SERIALIZER_PARITY_EN
    localparam logic [1:0] ST_PARITY = 2'd2;
`endif

    logic [1:0]       state_q, state_nxt;
    logic [WIDTH-1:0] sreg_q, sreg_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic             dir_q, dir_nxt;
    // Holds load_ready low until the first clock edge after reset release.
    logic             armed_q;
    logic             serial_out_q, serial_valid_q, busy_q, frame_done_q;
    logic             last_now, accept, bit_nxt, last_nxt;
`ifdef SERIALIZER_PARITY_EN
    logic             parity_q, parity_nxt;
`endif

    // The final cycle of the current frame: the only non-idle cycle in which
    // a new word may be taken, so the next frame follows without a gap.
    always_comb begin
`ifdef SERIALIZER_PARITY_EN
        last_now = (state_q == ST_PARITY);
`else
        last_now = (state_q == ST_SHIFT) && (cnt_q == LAST_CNT);
`endif
    end

    assign load_ready = armed_q && ((state_q == ST_IDLE) || last_now);
    assign accept     = load_valid && load_ready;

    // Next-state computation. sreg always holds the current bit at the output
    // end selected by dir (bit 0 for right shifts, bit WIDTH-1 for left).
    always_comb begin
        state_nxt  = state_q;
        sreg_nxt   = sreg_q;
        cnt_nxt    = cnt_q;
        dir_nxt    = dir_q;
`ifdef SERIALIZER_PARITY_EN
        parity_nxt = parity_q;
`endif
        if (accept) begin
            state_nxt  = ST_SHIFT;
            sreg_nxt   = load_data;
            cnt_nxt    = '0;
            dir_nxt    = shift_dir;
`ifdef SERIALIZER_PARITY_EN
            parity_nxt = ^load_data;
`endif
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    if (cnt_q == LAST_CNT) begin
`ifdef SERIALIZER_PARITY_EN
                        state_nxt = ST_PARITY;
`else
                        state_nxt = ST_IDLE;
`endif
                    end else begin
                        cnt_nxt  = cnt_q + CNT_W'(1);
                        sreg_nxt = dir_q ? {sreg_q[WIDTH-2:0], 1'b0}
                                         : {1'b0, sreg_q[WIDTH-1:1]};
                    end
                end
`ifdef SERIALIZER_PARITY_EN
                ST_PARITY: state_nxt = ST_IDLE;
`endif
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    // Values the registered outputs take in the cycle after this edge.
    always_comb begin
        bit_nxt  = 1'b0;
        last_nxt = 1'b0;
        case (state_nxt)
            ST_SHIFT: begin
                bit_nxt = dir_nxt ? sreg_nxt[WIDTH-1] : sreg_nxt[0];
`ifndef SERIALIZER_PARITY_EN
                last_nxt = (cnt_nxt == LAST_CNT);
`endif
            end
`ifdef SERIALIZER_PARITY_EN
            ST_PARITY: begin
                bit_nxt  = parity_nxt;
                last_nxt = 1'b1;
            end
`endif
            default: begin
                bit_nxt  = 1'b0;
                last_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            sreg_q         <= '0;
            cnt_q          <= '0;
            dir_q          <= 1'b0;
            armed_q        <= 1'b0;
            serial_out_q   <= 1'b0;
            serial_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_nxt;
            sreg_q         <= sreg_nxt;
            cnt_q          <= cnt_nxt;
            dir_q          <= dir_nxt;
            armed_q        <= 1'b1;
            serial_out_q   <= bit_nxt;
            serial_valid_q <= (state_nxt != ST_IDLE);
            busy_q         <= (state_nxt != ST_IDLE);
            frame_done_q   <= last_nxt;
        end
    end

`ifdef SERIALIZER_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_nxt;
        end
    end
`endif

    assign serial_out   = serial_out_q;
    assign serial_valid = serial_valid_q;
    assign busy         = busy_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - self-checking bench for piso_serializer

module tb_piso_serializer;

    localparam int W = 4;
`ifdef SERIALIZER_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] load_data;
    logic         load_valid;
    logic         load_ready;
    logic         shift_dir;
    logic         serial_out;
    logic         serial_valid;
    logic         busy;
    logic         frame_done;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: queue of bits still to appear on serial_out; q[0] is
    // the bit expected in the current cycle.
    bit   q[$];
    bit   armed_m;
    logic rdy_seen, rdy_exp, acc;
    logic [3:0] out_exp;
    bit   obs_q[$];

    piso_serializer #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .shift_dir    (shift_dir),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    task automatic push_frame(input logic [W-1:0] d, input logic dir);
        for (int i = 0; i < W; i++) q.push_back(dir ? d[W-1-i] : d[i]);
`ifdef SERIALIZER_PARITY_EN
        q.push_back(^d);
`endif
    endtask

    function automatic logic [31:0] obs_vec();
        logic [31:0] v = '0;
        foreach (obs_q[i]) v = {v[30:0], obs_q[i]};
        return v;
    endfunction

    // Drives one clock of stimulus and advances the model; leaves observed
    // ready in rdy_seen and expected values in rdy_exp / out_exp.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic dir);
        load_valid = v;
        load_data  = d;
        shift_dir  = dir;
        #1;
        rdy_seen = load_ready;
        rdy_exp  = armed_m && (q.size() <= 1);
        acc      = v && rdy_exp;
        @(posedge clk);
        #1;
        if (q.size() > 0) void'(q.pop_front());
        if (acc) push_frame(d, dir);
        armed_m = 1'b1;
        out_exp = (q.size() > 0) ? {q[0], 1'b1, 1'b1, q.size() == 1} : 4'b0000;
        if (serial_valid === 1'b1) obs_q.push_back(serial_out);
    endtask

    task automatic model_reset();
        q.delete();
        armed_m = 1'b0;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        shift_dir  = 1'b0;
        model_reset();
        #1;
        vectors++;
        if ({serial_out, serial_valid, busy, frame_done, load_ready} !== 5'b00000) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected 00000",
                     {serial_out, serial_valid, busy, frame_done, load_ready});
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        #1;
        vectors++;
        if (load_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_ready: got %b expected 0", load_ready);
        end
        for (int c = 0; c < 3; c++) begin
            cycle(1'b0, '0, 1'b0);
            vectors++;
            if (rdy_seen !== rdy_exp) begin
                miscompares++;
                $display("FAIL reset_ready cyc%0d: got %b expected %b", c, rdy_seen, rdy_exp);
            end
            vectors++;
            if ({serial_out, serial_valid, busy, frame_done} !== out_exp) begin
                miscompares++;
                $display("FAIL reset_idle cyc%0d: got %b expected %b", c,
                         {serial_out, serial_valid, busy, frame_done}, out_exp);
            end
        end
    endtask

    // One word, then drain; checks every cycle, the serial sequence, and a
    // SIPO model shifting in the same direction.
    task automatic test_single_frame(input string name, input logic [W-1:0] word,
                                     input logic dir, input logic [31:0] exp_seq);
        logic [W-1:0] sipo = '0;
        obs_q.delete();
        for (int c = 0; c < FRAME + 2; c++) begin
            cycle(c == 0, word, dir);
            vectors++;
            if (rdy_seen !== rdy_exp) begin
                miscompares++;
                $display("FAIL %s ready cyc%0d: got %b expected %b", name, c, rdy_seen, rdy_exp);
            end
            vectors++;
            if ({serial_out, serial_valid, busy, frame_done} !== out_exp) begin
                miscompares++;
                $display("FAIL %s outputs cyc%0d: got %b expected %b", name, c,
                         {serial_out, serial_valid, busy, frame_done}, out_exp);
            end
        end
        vectors++;
        if (obs_q.size() !== FRAME || obs_vec() !== exp_seq) begin
            miscompares++;
            $display("FAIL %s sequence: got %0d bits %b expected %0d bits %b", name,
                     obs_q.size(), obs_vec(), FRAME, exp_seq);
        end
        for (int i = 0; i < W && i < obs_q.size(); i++)
            sipo = dir ? {sipo[W-2:0], obs_q[i]} : {obs_q[i], sipo[W-1:1]};
        vectors++;
        if (sipo !== word) begin
            miscompares++;
            $display("FAIL %s sipo_rebuild: got %b expected %b", name, sipo, word);
        end
    endtask

    task automatic test_lsb_first();
`ifdef SERIALIZER_PARITY_EN
        test_single_frame("lsb_first", 4'b1011, 1'b0, 32'b11011);
`else
        test_single_frame("lsb_first", 4'b1011, 1'b0, 32'b1101);
`endif
    endtask

    task automatic test_msb_first();
`ifdef SERIALIZER_PARITY_EN
        test_single_frame("msb_first", 4'b1011, 1'b1, 32'b10111);
`else
        test_single_frame("msb_first", 4'b1011, 1'b1, 32'b1011);
`endif
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words [2] = '{4'b0110, 4'b1001};
        int  idx = 0;
        bit  started = 0, gap = 0;
        obs_q.delete();
        for (int c = 0; c < 40 && !(idx == 2 && q.size() == 0); c++) begin
            cycle(idx < 2, (idx < 2) ? words[idx] : '0, 1'b0);
            if (acc) idx++;
            if (serial_valid === 1'b1) started = 1;
            else if (started && obs_q.size() < 2 * FRAME) gap = 1;
            vectors++;
            if (rdy_seen !== rdy_exp) begin
                miscompares++;
                $display("FAIL b2b ready cyc%0d: got %b expected %b", c, rdy_seen, rdy_exp);
            end
            vectors++;
            if ({serial_out, serial_valid, busy, frame_done} !== out_exp) begin
                miscompares++;
                $display("FAIL b2b outputs cyc%0d: got %b expected %b", c,
                         {serial_out, serial_valid, busy, frame_done}, out_exp);
            end
        end
        vectors++;
        if (idx != 2 || q.size() != 0) begin
            miscompares++;
            $display("FAIL b2b timeout: got %0d words accepted expected 2", idx);
        end
        vectors++;
        if (gap) begin
            miscompares++;
            $display("FAIL b2b bubble: got serial_valid gap expected none");
        end
        vectors++;
`ifdef SERIALIZER_PARITY_EN
        if (obs_vec() !== 32'b0110010010 || obs_q.size() != 10) begin
            miscompares++;
            $display("FAIL b2b sequence: got %b expected %b", obs_vec(), 32'b0110010010);
        end
`else
        if (obs_vec() !== 32'b01101001 || obs_q.size() != 8) begin
            miscompares++;
            $display("FAIL b2b sequence: got %b expected %b", obs_vec(), 32'b01101001);
        end
`endif
    endtask

    task automatic test_mid_reset();
        obs_q.delete();
        cycle(1'b1, 4'b1111, 1'b0);
        cycle(1'b0, '0, 1'b0);
        vectors++;
        if ({serial_out, serial_valid, busy, frame_done} !== out_exp) begin
            miscompares++;
            $display("FAIL mid_reset pre: got %b expected %b",
                     {serial_out, serial_valid, busy, frame_done}, out_exp);
        end
        reset_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if ({serial_out, serial_valid, busy, frame_done, load_ready} !== 5'b00000) begin
            miscompares++;
            $display("FAIL mid_reset abort: got %b expected 00000",
                     {serial_out, serial_valid, busy, frame_done, load_ready});
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cycle(1'b0, '0, 1'b0);
            vectors++;
            if ({serial_out, serial_valid, busy, frame_done} !== 4'b0000
                || rdy_seen !== rdy_exp) begin
                miscompares++;
                $display("FAIL mid_reset no_bits cyc%0d: got %b/%b expected 0000/%b", c,
                         {serial_out, serial_valid, busy, frame_done}, rdy_seen, rdy_exp);
            end
        end
`ifdef SERIALIZER_PARITY_EN
        test_single_frame("post_reset", 4'b0101, 1'b0, 32'b10100);
`else
        test_single_frame("post_reset", 4'b0101, 1'b0, 32'b1010);
`endif
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 59) == 0) begin
                reset_n = 1'b0;
                model_reset();
                #1;
                vectors++;
                if ({serial_out, serial_valid, busy, frame_done, load_ready} !== 5'b00000) begin
                    miscompares++;
                    $display("FAIL rand reset cyc%0d: got %b expected 00000", c,
                             {serial_out, serial_valid, busy, frame_done, load_ready});
                end
                @(posedge clk); #1;
                reset_n = 1'b1;
            end
            cycle($urandom_range(0, 9) < 6, W'($urandom), 1'($urandom));
            vectors++;
            if (rdy_seen !== rdy_exp) begin
                miscompares++;
                $display("FAIL rand ready cyc%0d: got %b expected %b", c, rdy_seen, rdy_exp);
            end
            vectors++;
            if ({serial_out, serial_valid, busy, frame_done} !== out_exp) begin
                miscompares++;
                $display("FAIL rand outputs cyc%0d: got %b expected %b", c,
                         {serial_out, serial_valid, busy, frame_done}, out_exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
